// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`ifndef DIV_UNIT_SHARED_DEFS
`define DIV_UNIT_SHARED_DEFS
`define ENABLED 1'b1
`endif

package div_unit_pkg;

    localparam int unsigned DW = 32;  // operand / result width
    localparam int unsigned CW = 6;   // iteration counter width (0..32)

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        FIX  = 2'd3
    } div_state_t;

    // Two's complement negate when neg is set.
    function automatic logic [DW-1:0] cond_neg(input logic [DW-1:0] v, input logic neg);
        return neg ? (~v + DW'(1)) : v;
    endfunction

    // Magnitude of v; only negative values in signed mode are flipped.
    function automatic logic [DW-1:0] mag(input logic [DW-1:0] v, input logic sgn);
        return cond_neg(v, sgn && v[DW-1]);
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the divider and its issuing stage.
// Latency: n/a (wires only).
// Backpressure: requester must hold off while busy; starts seen while busy are dropped.
interface div_unit_if;
    import div_unit_pkg::*;

    logic          ena;
    logic          start;
    logic          is_signed;
    logic [DW-1:0] dividend;
    logic [DW-1:0] divisor;
    logic [DW-1:0] dividend_lz;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [DW-1:0] remainder;
    logic          div_by_zero;

    modport master (
        output ena, start, is_signed, dividend, divisor, dividend_lz,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  ena, start, is_signed, dividend, divisor, dividend_lz,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/div_unit_div_step.sv
// One restoring-division iteration: shift in next dividend bit, trial subtract, pick quotient bit.
// Latency: combinational.
// Backpressure: none.
module div_step
    import div_unit_pkg::*;
(
    input  logic [DW-1:0] rem,
    input  logic [DW-1:0] dvd,
    input  logic [DW-1:0] dsr,
    output logic [DW-1:0] rem_next,
    output logic [DW-1:0] dvd_next
);

    logic [DW:0] shifted;
    logic [DW:0] trial;

    // rem < dsr is invariant, so shifted < 2*dsr and the 33-bit sign bit of trial is exact.
    always_comb begin
        shifted = {rem, dvd[DW-1]};
        trial   = shifted - {1'b0, dsr};
        if (!trial[DW]) begin
            rem_next = trial[DW-1:0];
            dvd_next = {dvd[DW-2:0], 1'b1};
        end else begin
            rem_next = shifted[DW-1:0];
            dvd_next = {dvd[DW-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit DIV/DIVU with early-out from the upstream leading-zero count.
// Latency: done n+2 enabled cycles after accept (n = 32-lz, 32 for negative signed, 0 for /0).
// Backpressure: ena low freezes all state; start is ignored unless IDLE.
module div_unit
    import div_unit_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    div_unit_if.slave bus
);

    div_state_t    state;
    div_state_t    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] lz_c;
    logic [CW-1:0] n_req;
    logic [DW-1:0] dvd_r;     // raw dividend, then pre-shifted magnitude, then quotient bits
    logic [DW-1:0] dsr_r;     // raw divisor, then its magnitude
    logic [DW-1:0] rem_r;     // partial remainder
    logic          sgn_r;
    logic          zero_dsr;
    logic          neg_q;
    logic          neg_r;
    logic [DW-1:0] q_out;
    logic [DW-1:0] r_out;
    logic          dz_out;
    logic          busy_w;
    logic          done_w;
    logic          adv;
    logic [DW-1:0] step_rem;
    logic [DW-1:0] step_dvd;
    logic          unused_lz;

    assign adv       = (bus.ena == `ENABLED);
    assign unused_lz = ^bus.dividend_lz[DW-1:CW];

    div_step u_step (
        .rem      (rem_r),
        .dvd      (dvd_r),
        .dsr      (dsr_r),
        .rem_next (step_rem),
        .dvd_next (step_dvd)
    );

    // Iteration count for the incoming request; a zero divisor skips iterating entirely.
    always_comb begin
        lz_c = (bus.dividend_lz[CW-1:0] > CW'(DW)) ? CW'(DW) : bus.dividend_lz[CW-1:0];
        if (bus.divisor == '0) begin
            n_req = '0;
        end else if (bus.is_signed && bus.dividend[DW-1]) begin
            n_req = CW'(DW);
        end else begin
            n_req = CW'(DW) - lz_c;
        end
    end

    // State register; reset wins over ena.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; nothing moves while ena is low.
    always_comb begin
        state_nxt = state;
        if (adv) begin
            case (state)
                IDLE:    if (bus.start) state_nxt = LOAD;
                LOAD:    state_nxt = (cnt == '0) ? FIX : CALC;
                CALC:    if (cnt == CW'(1)) state_nxt = FIX;
                FIX:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Status outputs decoded from state; done coincides with the FIX cycle.
    always_comb begin
        busy_w = (state != IDLE);
        done_w = (state == FIX);
    end

    // Datapath. Results are sign-fixed and registered on the edge into FIX so they are
    // valid together with done and untouched by later iterations.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            dvd_r    <= '0;
            dsr_r    <= '0;
            rem_r    <= '0;
            sgn_r    <= 1'b0;
            zero_dsr <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            q_out    <= '0;
            r_out    <= '0;
            dz_out   <= 1'b0;
        end else if (adv) begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cnt      <= n_req;
                        dvd_r    <= bus.dividend;
                        dsr_r    <= bus.divisor;
                        sgn_r    <= bus.is_signed;
                        zero_dsr <= (bus.divisor == '0);
                    end
                end
                LOAD: begin
                    neg_r <= sgn_r && dvd_r[DW-1];
                    neg_q <= sgn_r && (dvd_r[DW-1] ^ dsr_r[DW-1]);
                    dvd_r <= mag(dvd_r, sgn_r) << (CW'(DW) - cnt);
                    dsr_r <= mag(dsr_r, sgn_r);
                    rem_r <= '0;
                    // No iterations: either divide-by-zero or a zero dividend.
                    if (cnt == '0) begin
                        q_out  <= zero_dsr ? {DW{1'b1}} : '0;
                        r_out  <= zero_dsr ? dvd_r : '0;
                        dz_out <= zero_dsr;
                    end
                end
                CALC: begin
                    dvd_r <= step_dvd;
                    rem_r <= step_rem;
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        q_out  <= cond_neg(step_dvd, neg_q);
                        r_out  <= cond_neg(step_rem, neg_r);
                        dz_out <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = busy_w;
    assign bus.done        = done_w;
    assign bus.quotient    = q_out;
    assign bus.remainder   = r_out;
    assign bus.div_by_zero = dz_out;

endmodule

// File: tb/tb_div_unit.sv
// Directed, table-driven bench for div_unit plus reset / busy-start sequences.
// Latency: measured per vector from the accept cycle to done.
// Backpressure: exercised with an ena-low window and a start issued while busy.
module tb_div_unit;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [31:0] prev_q;
    logic [31:0] prev_r;

    div_unit_if dif ();

    div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lz;
        int          lat;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          gap_at;
        int          gap_len;
        logic        poke;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] lz, input int lat, input logic [31:0] q,
                                input logic [31:0] r, input logic dz, input int gap_at,
                                input int gap_len, input logic poke);
        vec_t v;
        v.sgn = sgn; v.a = a; v.b = b; v.lz = lz; v.lat = lat; v.q = q; v.r = r;
        v.dz = dz; v.gap_at = gap_at; v.gap_len = gap_len; v.poke = poke;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cyc;
        bit got;
        bit hold_ok;
        int ndone;
        dif.is_signed   = v.sgn;
        dif.dividend    = v.a;
        dif.divisor     = v.b;
        dif.dividend_lz = v.lz;
        dif.ena         = 1'b1;
        dif.start       = 1'b1;
        cyc     = 0;
        got     = 1'b0;
        hold_ok = 1'b1;
        while (!got && cyc < 200) begin
            tick();
            cyc++;
            dif.start = 1'b0;
            if (v.poke && cyc == 2) begin
                dif.start    = 1'b1;
                dif.dividend = 32'd77;
                dif.divisor  = 32'd5;
            end
            if (v.gap_len > 0 && cyc == v.gap_at) dif.ena = 1'b0;
            if (v.gap_len > 0 && cyc == v.gap_at + v.gap_len) dif.ena = 1'b1;
            if (cyc == 1) chk($sformatf("v%0d busy_after_accept", idx), {31'b0, dif.busy}, 32'd1);
            if (dif.done) got = 1'b1;
            else if (dif.quotient !== prev_q || dif.remainder !== prev_r) hold_ok = 1'b0;
        end
        dif.start = 1'b0;
        dif.ena   = 1'b1;
        chk($sformatf("v%0d latency", idx), cyc, v.lat);
        chk($sformatf("v%0d hold_before_done", idx), {31'b0, hold_ok}, 32'd1);
        chk($sformatf("v%0d quotient", idx), dif.quotient, v.q);
        chk($sformatf("v%0d remainder", idx), dif.remainder, v.r);
        chk($sformatf("v%0d div_by_zero", idx), {31'b0, dif.div_by_zero}, {31'b0, v.dz});
        tick();
        chk($sformatf("v%0d idle_after_done", idx), {30'b0, dif.busy, dif.done}, 32'd0);
        prev_q = v.q;
        prev_r = v.r;
        if (v.poke) begin
            ndone = 0;
            for (int k = 0; k < 40; k++) begin
                tick();
                if (dif.done || dif.busy) ndone++;
            end
            chk($sformatf("v%0d busy_start_dropped", idx), ndone, 0);
        end
    endtask

    initial begin
        int ndone;
        total = 0;
        bad   = 0;

        //            sgn   a             b             lz     lat q             r             dz   gap   poke
        vecs[0]  = mk(1'b0, 32'd100,      32'd7,        32'd25, 9, 32'd14,       32'd2,        1'b0, 0, 0, 1'b0);
        vecs[1]  = mk(1'b1, 32'hFFFFFFF9, 32'd2,        32'd0, 34, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 0, 0, 1'b0);
        vecs[2]  = mk(1'b0, 32'd5,        32'd0,        32'd29, 2, 32'hFFFFFFFF, 32'd5,        1'b1, 0, 0, 1'b0);
        vecs[3]  = mk(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 34, 32'h80000000, 32'd0,        1'b0, 0, 0, 1'b0);
        vecs[4]  = mk(1'b0, 32'd1000,     32'd3,        32'd22, 17, 32'd333,     32'd1,        1'b0, 3, 5, 1'b1);
        vecs[5]  = mk(1'b0, 32'd0,        32'd9,        32'd32, 2, 32'd0,        32'd0,        1'b0, 0, 0, 1'b0);
        vecs[6]  = mk(1'b1, 32'd7,        32'hFFFFFFFE, 32'd29, 5, 32'hFFFFFFFD, 32'd1,        1'b0, 0, 0, 1'b0);
        vecs[7]  = mk(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd0, 34, 32'd3,        32'hFFFFFFFF, 1'b0, 0, 0, 1'b0);
        vecs[8]  = mk(1'b0, 32'hFFFFFFFF, 32'd1,        32'd0, 34, 32'hFFFFFFFF, 32'd0,        1'b0, 0, 0, 1'b0);
        vecs[9]  = mk(1'b0, 32'd100,      32'd7,        32'd0, 34, 32'd14,       32'd2,        1'b0, 0, 0, 1'b0);
        vecs[10] = mk(1'b0, 32'd100,      32'd7,        32'h59, 9, 32'd14,       32'd2,        1'b0, 0, 0, 1'b0);
        vecs[11] = mk(1'b0, 32'd3,        32'd10,       32'd30, 4, 32'd0,        32'd3,        1'b0, 0, 0, 1'b0);
        vecs[12] = mk(1'b1, 32'hFFFFFFFB, 32'd0,        32'd0, 2, 32'hFFFFFFFF,  32'hFFFFFFFB, 1'b1, 0, 0, 1'b0);
        vecs[13] = mk(1'b1, 32'd20,       32'd4,        32'd27, 7, 32'd5,        32'd0,        1'b0, 0, 0, 1'b0);
        vecs[14] = mk(1'b0, 32'd0,        32'd5,        32'd63, 2, 32'd0,        32'd0,        1'b0, 0, 0, 1'b0);

        // Reset with ena low and start high: everything must clear.
        rst             = 1'b1;
        dif.ena         = 1'b0;
        dif.start       = 1'b1;
        dif.is_signed   = 1'b0;
        dif.dividend    = 32'd12;
        dif.divisor     = 32'd4;
        dif.dividend_lz = 32'd28;
        tick();
        tick();
        chk("reset busy_done", {30'b0, dif.busy, dif.done}, 32'd0);
        chk("reset quotient", dif.quotient, 32'd0);
        chk("reset remainder", dif.remainder, 32'd0);
        chk("reset div_by_zero", {31'b0, dif.div_by_zero}, 32'd0);
        rst       = 1'b0;
        dif.start = 1'b0;
        dif.ena   = 1'b1;
        tick();
        chk("post_reset idle", {30'b0, dif.busy, dif.done}, 32'd0);
        prev_q = 32'd0;
        prev_r = 32'd0;

        for (int i = 0; i < NV; i++) begin
            run_vec(i, vecs[i]);
        end

        // Abort in the third CALC cycle, with a competing start in the reset cycle.
        dif.is_signed   = 1'b0;
        dif.dividend    = 32'd1000;
        dif.divisor     = 32'd3;
        dif.dividend_lz = 32'd22;
        dif.ena         = 1'b1;
        dif.start       = 1'b1;
        tick();
        dif.start = 1'b0;
        tick();
        tick();
        tick();
        chk("abort busy_in_calc", {31'b0, dif.busy}, 32'd1);
        rst          = 1'b1;
        dif.start    = 1'b1;
        dif.dividend = 32'd50;
        dif.divisor  = 32'd5;
        tick();
        rst       = 1'b0;
        dif.start = 1'b0;
        chk("abort busy_done", {30'b0, dif.busy, dif.done}, 32'd0);
        chk("abort quotient", dif.quotient, 32'd0);
        chk("abort remainder", dif.remainder, 32'd0);
        chk("abort div_by_zero", {31'b0, dif.div_by_zero}, 32'd0);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (dif.done || dif.busy) ndone++;
        end
        chk("abort no_done_no_restart", ndone, 0);
        prev_q = 32'd0;
        prev_r = 32'd0;
        run_vec(100, vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
